// File: rtl/alu32_issue_unit_pkg.sv
// Shared definitions for the alu32 issue unit: datapath widths and the ALU control codes.
// The width macros are guarded, so whichever file is compiled first defines them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 4
`endif

package alu32_issue_unit_pkg;
  localparam logic [`CTRL_WIDTH-1:0] ALU_AND = 4'b0000;
  localparam logic [`CTRL_WIDTH-1:0] ALU_OR  = 4'b0001;
  localparam logic [`CTRL_WIDTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [`CTRL_WIDTH-1:0] ALU_SUB = 4'b0110;
  localparam logic [`CTRL_WIDTH-1:0] ALU_SLT = 4'b0111;
  localparam logic [`CTRL_WIDTH-1:0] ALU_NOR = 4'b1100;

  typedef logic [`DATA_WIDTH-1:0] data_t;
  typedef logic [`CTRL_WIDTH-1:0] ctrl_t;
endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU: bitwise, add/sub and signed set-less-than, with a zero flag.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 4
`endif

module alu32
  import alu32_issue_unit_pkg::*;
(
  input  logic [`DATA_WIDTH-1:0] in1,
  input  logic [`DATA_WIDTH-1:0] in2,
  input  logic [`CTRL_WIDTH-1:0] ctrl,
  output logic [`DATA_WIDTH-1:0] result,
  output logic                   iszero
);
  logic signed [`DATA_WIDTH-1:0] a_s;
  logic signed [`DATA_WIDTH-1:0] b_s;

  assign a_s = in1;
  assign b_s = in2;

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = in1 & in2;
      ALU_OR:  result = in1 | in2;
      ALU_ADD: result = a_s + b_s;
      ALU_SUB: result = a_s - b_s;
      ALU_SLT: result = (a_s < b_s) ? `DATA_WIDTH'(1) : '0;
      ALU_NOR: result = ~(in1 | in2);
      default: result = '0;
    endcase
  end

  assign iszero = (result == '0);
endmodule

// File: rtl/alu32_issue_unit_resp_fifo.sv
// Response FIFO holding {result, iszero, tag} entries; power-of-two depth, pointers wrap naturally.
module alu32_resp_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // When full, a push lands on the slot being popped in the same cycle, which is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
endmodule

// File: rtl/alu32_issue_unit.sv
// Issue front-end for alu32: registers one request, evaluates it, and queues the result
// for the writeback consumer behind a valid/ready response port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 4
`endif

module alu32_issue_unit
  import alu32_issue_unit_pkg::*;
#(
  parameter int TAG_WIDTH  = 4,
  parameter int RESP_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [`DATA_WIDTH-1:0] req_in1,
  input  logic [`DATA_WIDTH-1:0] req_in2,
  input  logic [`CTRL_WIDTH-1:0] req_ctrl,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [`DATA_WIDTH-1:0] rsp_result,
  output logic                   rsp_iszero,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  output logic [CNT_WIDTH-1:0]   op_count
);
  localparam int EW  = `DATA_WIDTH + 1 + TAG_WIDTH;
  localparam int FCW = $clog2(RESP_DEPTH+1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  data_t                 in1_p0;
  data_t                 in2_p0;
  ctrl_t                 ctrl_p0;
  logic [TAG_WIDTH-1:0]  tag_p0;
  logic                  vld_p0;
  logic [CNT_WIDTH-1:0]  cnt_q;

  data_t                 alu_result;
  logic                  alu_iszero;
  logic [EW-1:0]         fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic                  pop;
  logic                  advance;
  logic                  fire;

  assign pop       = rsp_valid & rsp_ready;
  assign advance   = vld_p0 & (!fifo_full | pop);
  assign req_ready = !vld_p0 | advance;
  assign fire      = req_valid & req_ready;

  // Stage p0: operand registers; they hold while the FIFO backs up so the ALU inputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_p0  <= '0;
      in2_p0  <= '0;
      ctrl_p0 <= '0;
      tag_p0  <= '0;
      vld_p0  <= 1'b0;
    end else begin
      if (fire) begin
        in1_p0  <= req_in1;
        in2_p0  <= req_in2;
        ctrl_p0 <= req_ctrl;
        tag_p0  <= req_tag;
      end
      vld_p0 <= fire | (vld_p0 & !advance);
    end
  end

  alu32 u_alu (
    .in1    (in1_p0),
    .in2    (in2_p0),
    .ctrl   (ctrl_p0),
    .result (alu_result),
    .iszero (alu_iszero)
  );

  // Stage p1: response queue, written directly from the ALU outputs.
  alu32_resp_fifo #(
    .WIDTH (EW),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (advance),
    .pop   (pop),
    .wdata ({alu_result, alu_iszero, tag_p0}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign {rsp_result, rsp_iszero, rsp_tag} = fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (pop) cnt_q <= sat_inc(cnt_q);
  end

  assign op_count = cnt_q;

  a_full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_count == FCW'(RESP_DEPTH)));
endmodule
